sram_upload: RTL and testbench
==============================

SRAM_UPLOAD -- requirements
Module: sram_upload

Interface
REQ-001 SHALL have parameter AW, default 16, meaning SRAM byte-address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO depth in bytes (power of two, 2..16).
REQ-003 SHALL have port clock  in  1  sole clock (system clock, 56 MHz in the target build).
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port upload  in  1  host upload-session level; high for the whole session.
REQ-006 SHALL have port start  in  AW  first SRAM byte address, sampled on the upload rising edge.
REQ-007 SHALL have port length  in  AW+1  byte count, sampled on the upload rising edge.
REQ-008 SHALL have port ce  in  1  host-side clock enable qualifying rd.
REQ-009 SHALL have port rd  in  1  host read strobe; consumes one byte when rd&ce.
REQ-010 SHALL have port dout  out  8  byte presented to the host (FIFO head).
REQ-011 SHALL have port ready  out  1  FIFO non-empty.
REQ-012 SHALL have port done  out  1  all length bytes consumed by the host.
REQ-013 SHALL have port underrun  out  1  sticky: a read occurred while ready=0.
REQ-014 SHALL have port slot  in  1  SRAM bus free this cycle (video not fetching).
REQ-015 SHALL have port sramRd  out  1  SRAM read request for this cycle.
REQ-016 SHALL have port sramA  out  AW  SRAM address, valid while sramRd=1.
REQ-017 SHALL have port sramD  in  8  SRAM data, valid exactly one clock after sramRd.
REQ-018 SHALL have port busy  out  1  session active (IDLE state not current).
REQ-019 SHALL have port csum  out  8  running checksum (see Configuration).

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, CAPTURE, DRAIN.
REQ-021 IDLE->FETCH on the upload rising edge; latch addr=start and remaining=length; if length=0, go to DRAIN instead.
REQ-022 In FETCH, SHALL assert sramRd with sramA=addr only when slot=1, remaining>0 and FIFO count+pending<DEPTH; on assertion, go to CAPTURE.
REQ-023 In CAPTURE (one clock), SHALL push sramD into the FIFO, set addr=addr+1 modulo 2^AW, decrement remaining, then return to FETCH, or go to DRAIN if remaining reaches 0.
REQ-024 Read latency SHALL be: a byte is visible on dout/ready two clocks after its sramRd, given an empty FIFO.
REQ-025 SHALL pop the FIFO on rd&ce&ready; dout SHALL update on the next clock.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged with no data loss.
REQ-027 SHALL set underrun on rd&ce&!ready; dout SHALL hold its last value and no byte is consumed.
REQ-028 In DRAIN, done SHALL assert when the FIFO is empty and remain high until upload falls.
REQ-029 When upload falls in any state, SHALL flush the FIFO and go to IDLE the next clock; sramRd SHALL drop immediately (combinational).
REQ-030 Address wrap-around from 2^AW-1 to 0 SHALL be seamless within a session.
REQ-031 sramRd SHALL never assert while slot=0 or in IDLE.

Reset
REQ-032 reset=0 SHALL asynchronously force: state IDLE, FIFO empty, addr=0, remaining=0, dout=8'h00, ready=0, done=0, underrun=0, sramRd=0, busy=0, csum=0.
REQ-033 underrun and csum SHALL also clear on each upload rising edge.

Configuration
REQ-034 With macro SRAM_UPLOAD_CHECKSUM_EN defined, csum SHALL equal the modulo-256 sum of all bytes popped in the current session, updated the clock after each pop.
REQ-035 Without SRAM_UPLOAD_CHECKSUM_EN, csum SHALL be constant 8'h00 and no checksum logic SHALL be synthesized.

Verification
REQ-036 SRAM model with [0x1000..0x1003]=11,22,33,44, slot=1, start=0x1000, length=4, host pops every 8 clocks -> dout sequence 11,22,33,44; done=1; csum=0xAA (with macro defined).
REQ-037 slot=1 only every 8th clock, length=6 -> sramRd coincides only with slot=1; all 6 bytes delivered in order.
REQ-038 Host never reads, length=10, DEPTH=4 -> exactly 4 sramRd pulses, then stall; ready=1.
REQ-039 start=0xFFFE, length=4 -> sramA sequence FFFE, FFFF, 0000, 0001.
REQ-040 length=0 -> no sramRd; done=1 within 2 clocks; rd with ce on an empty FIFO -> underrun=1.
REQ-041 upload falls after 2 bytes pushed -> sramRd=0 the same cycle; ready=0 and busy=0 the next clock; a new session restarts cleanly at its new start address.

Source files
------------

// File: rtl/sram_upload.sv
// sram_upload: streams a block of SRAM bytes to a host through a small
// prefetch FIFO. SRAM reads are only issued in cycles where the video side
// leaves the bus free (slot=1); the host pops bytes with rd&ce.
//
// Optional build macro: SRAM_UPLOAD_CHECKSUM_EN enables the running modulo-256
// checksum of popped bytes on csum; without it csum is tied to 8'h00.
//
// Ports:
//   clock, reset     sole clock, asynchronous active-low reset
//   upload           session level; rising edge samples start/length
//   start, length    first byte address, byte count
//   ce, rd           host read strobe qualified by clock enable
//   dout, ready      FIFO head byte, FIFO non-empty
//   done             all bytes of the session consumed
//   underrun         sticky, host read while FIFO empty
//   slot             SRAM bus free this cycle
//   sramRd, sramA    SRAM read request and address
//   sramD            SRAM read data, one clock after sramRd
//   busy             session active
//   csum             running checksum of popped bytes
//
// State table
//   state   | meaning
//   IDLE    | no session; waits for upload rising edge
//   FETCH   | issues an SRAM read when slot free and FIFO has room
//   CAPTURE | SRAM data valid; push it into the FIFO
//   DRAIN   | all bytes fetched; done once the host empties the FIFO

module sram_upload #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          upload,
  input  logic [AW-1:0] start,
  input  logic [AW:0]   length,
  input  logic          ce,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          ready,
  output logic          done,
  output logic          underrun,
  input  logic          slot,
  output logic          sramRd,
  output logic [AW-1:0] sramA,
  input  logic [7:0]    sramD,
  output logic          busy,
  output logic [7:0]    csum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, DRAIN} state_t;

  state_t          state, state_nx;
  logic            upload_q;
  logic            rise;
  logic [AW-1:0]   addr;
  logic [AW:0]     remaining;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      last;
  logic            push, pop, flush;

  assign rise  = upload & ~upload_q;
  assign ready = (count != '0);
  assign pop   = rd & ce & ready;
  assign busy  = (state != IDLE);
  assign done  = (state == DRAIN) && (count == '0);
  assign sramA = addr;
  // Empty FIFO shows the most recently popped byte so dout never glitches
  // to stale storage contents.
  assign dout  = ready ? mem[rd_ptr] : last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      upload_q <= 1'b0;
    end else begin
      state    <= state_nx;
      upload_q <= upload;
    end
  end

  // Only one read is ever in flight and FETCH never overlaps CAPTURE, so the
  // room check in FETCH needs only the current count.
  always_comb begin
    state_nx = state;
    sramRd   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nx = (length == '0) ? DRAIN : FETCH;
      end
      FETCH: begin
        if (!upload) begin
          state_nx = IDLE;
          flush    = 1'b1;
        end else if (slot && (remaining != '0) && (count < DEPTH_C)) begin
          sramRd   = 1'b1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!upload) begin
          state_nx = IDLE;
          flush    = 1'b1;
        end else begin
          push     = 1'b1;
          state_nx = (remaining == (AW+1)'(1)) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (!upload) begin
          state_nx = IDLE;
          flush    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if ((state == IDLE) && rise) begin
      addr      <= start;
      remaining <= length;
    end else if (push) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= sramD;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= 8'h00;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                underrun <= 1'b0;
    else if (rise)             underrun <= 1'b0;
    else if (rd && ce && !ready) underrun <= 1'b1;
  end

`ifdef SRAM_UPLOAD_CHECKSUM_EN
  logic [7:0] csum_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    csum_r <= 8'h00;
    else if (rise) csum_r <= 8'h00;
    else if (pop)  csum_r <= csum_r + mem[rd_ptr];
  end

  assign csum = csum_r;
`else
  assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_sram_upload.sv
module tb_sram_upload;

  logic        clock = 1'b0;
  logic        reset;
  logic        upload;
  logic [15:0] start;
  logic [16:0] length;
  logic        ce, rd;
  logic [7:0]  dout;
  logic        ready, done, underrun;
  logic        slot;
  logic        sramRd;
  logic [15:0] sramA;
  logic [7:0]  sramD;
  logic        busy;
  logic [7:0]  csum;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int cyc   = 0;
  bit sparse = 1'b0;
  logic [15:0] pulse_q[$];
  logic [7:0]  sram [65536];

`ifdef SRAM_UPLOAD_CHECKSUM_EN
  localparam logic [7:0] CS_T1 = 8'hAA;
  localparam logic [7:0] CS_T4 = 8'hCE;
`else
  localparam logic [7:0] CS_T1 = 8'h00;
  localparam logic [7:0] CS_T4 = 8'h00;
`endif

  sram_upload #(.AW(16), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .upload(upload), .start(start),
    .length(length), .ce(ce), .rd(rd), .dout(dout), .ready(ready),
    .done(done), .underrun(underrun), .slot(slot), .sramRd(sramRd),
    .sramA(sramA), .sramD(sramD), .busy(busy), .csum(csum)
  );

  always #5 clock = ~clock;

  always @(posedge clock) sramD <= sram[sramA];

  always @(posedge clock) begin
    if (sramRd) begin
      pulse_q.push_back(sramA);
      if (!slot || !busy) viol++;
    end
  end

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (sparse) slot = (cyc % 8 == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_session(input logic [15:0] s, input logic [16:0] l);
    pulse_q.delete();
    start  = s;
    length = l;
    upload = 1'b1;
    tick();
  endtask

  task automatic end_session();
    upload = 1'b0;
    rd = 1'b0;
    ce = 1'b0;
    tick();
    tick();
  endtask

  task automatic host_drain(input int n, input logic [15:0] base);
    int k = 0;
    int guard = 0;
    logic [15:0] a;
    while (k < n && guard < 400) begin
      tick();
      guard++;
      if (ready) begin
        a = base + 16'(k);
        chk("drain_dout", {24'h0, dout}, {24'h0, sram[a]});
        k++;
        rd = 1'b1;
        ce = 1'b1;
      end else begin
        rd = 1'b0;
        ce = 1'b0;
      end
    end
    tick();
    rd = 1'b0;
    ce = 1'b0;
    chk("drain_count", k, n);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
    sram[16'h1000] = 8'h11; sram[16'h1001] = 8'h22;
    sram[16'h1002] = 8'h33; sram[16'h1003] = 8'h44;
    for (int i = 0; i < 6; i++)  sram[16'h2000 + i] = 8'hA1 + 8'(i);
    for (int i = 0; i < 10; i++) sram[16'h3000 + i] = 8'h30 + 8'(i);
    sram[16'hFFFE] = 8'h5A; sram[16'hFFFF] = 8'h6B;
    sram[16'h0000] = 8'h7C; sram[16'h0001] = 8'h8D;
    sram[16'h5000] = 8'hC3; sram[16'h5001] = 8'hD4;

    reset = 1'b0; upload = 1'b0; start = '0; length = '0;
    ce = 1'b0; rd = 1'b0; slot = 1'b1;
    tick(); tick();
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_sramrd", sramRd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_csum", {24'h0, csum}, 32'h0);
    reset = 1'b1;
    tick(); tick();

    // basic session, host pops every 8 clocks
    start_session(16'h1000, 17'd4);
    chk("t1_busy", busy, 1);
    chk("t1_sramrd", sramRd, 1);
    chk("t1_srama", {16'h0, sramA}, 32'h1000);
    tick();
    chk("t1_lat_not_ready", ready, 0);
    tick();
    chk("t1_lat_ready", ready, 1);
    chk("t1_lat_dout", {24'h0, dout}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      repeat (7) tick();
      chk("t1_dout", {24'h0, dout}, {24'h0, sram[16'h1000 + i]});
      rd = 1'b1; ce = 1'b1;
      tick();
      rd = 1'b0; ce = 1'b0;
    end
    chk("t1_done", done, 1);
    chk("t1_ready", ready, 0);
    chk("t1_csum", {24'h0, csum}, {24'h0, CS_T1});
    chk("t1_pulses", pulse_q.size(), 4);
    chk("t1_underrun", underrun, 0);
    end_session();
    chk("t1_idle", busy, 0);
    chk("t1_done_low", done, 0);

    // sparse slot
    sparse = 1'b1;
    start_session(16'h2000, 17'd6);
    host_drain(6, 16'h2000);
    sparse = 1'b0;
    slot = 1'b1;
    chk("t2_done", done, 1);
    chk("t2_pulses", pulse_q.size(), 6);
    chk("t2_slot_viol", viol, 0);
    chk("t2_underrun", underrun, 0);
    end_session();

    // host never reads: prefetch stalls at FIFO depth
    start_session(16'h3000, 17'd10);
    repeat (40) tick();
    chk("t3_pulses", pulse_q.size(), 4);
    chk("t3_ready", ready, 1);
    chk("t3_dout", {24'h0, dout}, 32'h30);
    chk("t3_done", done, 0);
    chk("t3_sramrd", sramRd, 0);
    end_session();

    // address wrap
    start_session(16'hFFFE, 17'd4);
    host_drain(4, 16'hFFFE);
    chk("t4_pulses", pulse_q.size(), 4);
    if (pulse_q.size() == 4) begin
      chk("t4_a0", {16'h0, pulse_q[0]}, 32'hFFFE);
      chk("t4_a1", {16'h0, pulse_q[1]}, 32'hFFFF);
      chk("t4_a2", {16'h0, pulse_q[2]}, 32'h0000);
      chk("t4_a3", {16'h0, pulse_q[3]}, 32'h0001);
    end
    chk("t4_done", done, 1);
    chk("t4_csum", {24'h0, csum}, {24'h0, CS_T4});
    end_session();

    // zero length, then underrun
    start_session(16'h6000, 17'd0);
    chk("t5_done", done, 1);
    chk("t5_csum_clr", {24'h0, csum}, 32'h0);
    rd = 1'b1; ce = 1'b0;
    tick();
    chk("t5_no_ce", underrun, 0);
    ce = 1'b1;
    tick();
    rd = 1'b0; ce = 1'b0;
    chk("t5_underrun", underrun, 1);
    chk("t5_dout_hold", {24'h0, dout}, 32'h8D);
    chk("t5_pulses", pulse_q.size(), 0);
    tick();
    chk("t5_sticky", underrun, 1);
    end_session();

    // abort mid-session, then clean restart
    start_session(16'h4000, 17'd8);
    chk("t6_underrun_clr", underrun, 0);
    repeat (4) tick();
    chk("t6_ready", ready, 1);
    chk("t6_sramrd_pre", sramRd, 1);
    upload = 1'b0;
    #1;
    chk("t6_sramrd_drop", sramRd, 0);
    tick();
    chk("t6_ready_flush", ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pulses", pulse_q.size(), 2);
    tick();
    start_session(16'h5000, 17'd2);
    chk("t6_restart_a", {16'h0, sramA}, 32'h5000);
    host_drain(2, 16'h5000);
    chk("t6_restart_done", done, 1);
    chk("t6_restart_pulses", pulse_q.size(), 2);
    chk("t6_slot_viol", viol, 0);
    end_session();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
